// File: rtl/n_to_1_aging_arbiter_pkg.sv
// Shared flit format and arbiter type definitions.
package n_to_1_aging_arbiter_pkg;

    localparam int FLIT_SIZE  = 16;
    localparam int HEADER_LEN = 2;

    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b01;
    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b10;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    // Priority field sits directly below the header.
    localparam int CMP_POS = 13;
    localparam int CMP_LEN = 4;

    typedef enum logic [HEADER_LEN-1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic flit_type_t flit_type(input logic [FLIT_SIZE-1:0] f);
        return flit_type_t'(f[FLIT_SIZE-1 -: HEADER_LEN]);
    endfunction

endpackage

// File: rtl/n_to_1_aging_arbiter_fifo.sv
// Per-input flit FIFO; head is the oldest entry, valid whenever !empty.
module flit_fifo #(
    parameter int DEPTH     = 2,
    parameter int FLIT_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [FLIT_SIZE-1:0] din,
    output logic                 full,
    output logic                 empty,
    output logic [FLIT_SIZE-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [FLIT_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/n_to_1_aging_arbiter.sv
// N-input wormhole flit arbiter: priority + aging + round-robin selection,
// per-input FIFOs, orphan BODY/TAIL flit removal.
module n_to_1_aging_arbiter
    import n_to_1_aging_arbiter_pkg::*;
#(
    parameter int N     = 6,
    parameter int DEPTH = 2,
    parameter int AGE_W = 4,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE*N-1:0] in,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_avail,
    output logic [FLIT_SIZE-1:0]   out,
    output logic                   out_valid,
    input  logic                   out_avail,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic                   locked,
    output logic                   err_orphan
);

    localparam int SW = $clog2(N);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [FLIT_SIZE-1:0] head [N];
    logic [CMP_LEN-1:0]   prio [N];
    logic [AGE_W-1:0]     age  [N];
    logic [N-1:0]         full, empty, push, pop, cand, orphan, orphan_pop;

    arb_state_t  state;
    logic [SW-1:0] sel_reg, rr_ptr, winner, cur_sel, idx;
    logic [SW:0]   idx_full;
    logic          held, found, found_aged, orphan_found, xfer;
    logic [CMP_LEN-1:0] best;
    flit_type_t    sel_type;

    for (genvar i = 0; i < N; i++) begin : g_lane
        flit_fifo #(.DEPTH(DEPTH), .FLIT_SIZE(FLIT_SIZE)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in[FLIT_SIZE*i +: FLIT_SIZE]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
        assign cand[i]     = !empty[i] && (flit_type(head[i]) == FT_HEAD ||
                                           flit_type(head[i]) == FT_SINGLE);
        assign orphan[i]   = !empty[i] && (flit_type(head[i]) == FT_BODY ||
                                           flit_type(head[i]) == FT_TAIL);
        assign prio[i]     = head[i][CMP_POS -: CMP_LEN];
        assign in_avail[i] = !full[i] || pop[i];
        assign push[i]     = in_valid[i] && in_avail[i];
    end

    // Winner search in round-robin order starting at rr_ptr; a saturated age
    // pre-empts priority, otherwise strict '>' keeps the earliest of equals.
    always_comb begin
        winner     = rr_ptr;
        found      = 1'b0;
        found_aged = 1'b0;
        best       = '0;
        idx_full   = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx_full = {1'b0, rr_ptr} + (SW+1)'(k);
            if (idx_full >= (SW+1)'(N)) idx_full = idx_full - (SW+1)'(N);
            idx = idx_full[SW-1:0];
            if (cand[idx]) begin
                if (MODE == 0 && age[idx] == AGE_MAX && !found_aged) begin
                    winner     = idx;
                    found_aged = 1'b1;
                end else if (!found_aged &&
                             (!found || (MODE == 0 && prio[idx] > best))) begin
                    winner = idx;
                    best   = prio[idx];
                    found  = 1'b1;
                end
            end
        end
    end

    // Selection is frozen while locked or while a stalled offer is pending.
    always_comb begin
        cur_sel = sel_reg;
        if (state == IDLE && !held && |cand) cur_sel = winner;
    end

    assign out_sel   = cur_sel;
    assign out_valid = (state == LOCKED) ? !empty[cur_sel] : cand[cur_sel];
    assign out       = out_valid ? head[cur_sel] : '0;
    assign sel_type  = flit_type(head[cur_sel]);
    assign xfer      = out_valid && out_avail;
    assign locked    = (state == LOCKED) || (out_valid && sel_type == FT_HEAD);

    // Pop the granted lane plus at most one orphan head (lowest index) in IDLE.
    always_comb begin
        orphan_pop   = '0;
        orphan_found = 1'b0;
        if (state == IDLE) begin
            for (int i = 0; i < N; i++) begin
                if (orphan[i] && !orphan_found) begin
                    orphan_pop[i] = 1'b1;
                    orphan_found  = 1'b1;
                end
            end
        end
        pop = orphan_pop;
        if (xfer) pop[cur_sel] = 1'b1;
    end

    // Arbitration FSM: grant bookkeeping, wormhole lock and orphan pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_reg    <= '0;
            held       <= 1'b0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            err_orphan <= |orphan_pop;
            case (state)
                IDLE: begin
                    if (|cand) begin
                        sel_reg <= cur_sel;
                        if (xfer) begin
                            held   <= 1'b0;
                            rr_ptr <= (cur_sel == SW'(N - 1)) ? '0 : cur_sel + SW'(1);
                            if (sel_type == FT_HEAD) state <= LOCKED;
                        end else begin
                            held <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && sel_type == FT_TAIL) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Age counters: granted lane clears, every other waiting candidate saturates up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    if (state == IDLE && xfer && cur_sel == SW'(i))
                        age[i] <= '0;
                    else if (age[i] != AGE_MAX)
                        age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_n_to_1_aging_arbiter.sv
module tb_n_to_1_aging_arbiter;
    import n_to_1_aging_arbiter_pkg::*;

    localparam int N     = 6;
    localparam int DEPTH = 2;
    localparam int AGE_W = 2;
    localparam int MODE  = 0;
    localparam int SW    = $clog2(N);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [FLIT_SIZE*N-1:0] in_bus = '0;
    logic [N-1:0]           in_valid = '0;
    logic [N-1:0]           in_avail;
    logic [FLIT_SIZE-1:0]   out;
    logic                   out_valid;
    logic                   out_avail = 1'b0;
    logic [SW-1:0]          out_sel;
    logic                   locked;
    logic                   err_orphan;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [SW-1:0]        sel;
        logic [FLIT_SIZE-1:0] flit;
        logic                 lk;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    n_to_1_aging_arbiter #(.N(N), .DEPTH(DEPTH), .AGE_W(AGE_W), .MODE(MODE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_bus),
        .in_valid   (in_valid),
        .in_avail   (in_avail),
        .out        (out),
        .out_valid  (out_valid),
        .out_avail  (out_avail),
        .out_sel    (out_sel),
        .locked     (locked),
        .err_orphan (err_orphan)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [FLIT_SIZE-1:0] mk(input logic [1:0] t, input logic [3:0] p,
                                               input logic [9:0] d);
        return {t, p, d};
    endfunction

    function automatic void exp_push(input int sel, input logic [FLIT_SIZE-1:0] f, input logic lk);
        exp_t e;
        e.sel  = SW'(sel);
        e.flit = f;
        e.lk   = lk;
        sb.push_back(e);
    endfunction

    task automatic set_lane(input int i, input logic v, input logic [FLIT_SIZE-1:0] f);
        in_bus[FLIT_SIZE*i +: FLIT_SIZE] = f;
        in_valid[i] = v;
    endtask

    // One clock: scoreboard compare at negedge, then return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_avail) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_xfer: got sel=%0d flit=%h, required no transfer", out_sel, out);
            end else begin
                e = sb.pop_front();
                if (out !== e.flit || out_sel !== e.sel || locked !== e.lk) begin
                    failures++;
                    $display("FAIL xfer: got sel=%0d flit=%h locked=%b, required sel=%0d flit=%h locked=%b",
                             out_sel, out, locked, e.sel, e.flit, e.lk);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d transfers outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_bus    = '0;
        out_avail = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        set_lane(2, 1'b1, mk(SINGLE_FLIT, 4'd3, 10'h122));
        step();
        in_valid = '0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked: got %b required 0", locked); end
        checks++; if (out !== '0) begin failures++; $display("FAIL rst_out: got %h required 0", out); end
        checks++; if (out_sel !== '0) begin failures++; $display("FAIL rst_out_sel: got %0d required 0", out_sel); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL rst_err_orphan: got %b required 0", err_orphan); end
        checks++; if (in_avail !== '1) begin failures++; $display("FAIL rst_in_avail: got %b required all ones", in_avail); end
        do_reset();
    endtask

    task automatic test_priority();
        logic [FLIT_SIZE-1:0] f1, f3;
        do_reset();
        out_avail = 1'b1;
        f1 = mk(SINGLE_FLIT, 4'd5, 10'h011);
        f3 = mk(SINGLE_FLIT, 4'd9, 10'h033);
        set_lane(1, 1'b1, f1);
        set_lane(3, 1'b1, f3);
        exp_push(3, f3, 1'b0);
        exp_push(1, f1, 1'b0);
        step();
        in_valid = '0;
        drain(6);
    endtask

    task automatic test_wormhole();
        logic [FLIT_SIZE-1:0] h0, b0, t0, h2, t2;
        do_reset();
        out_avail = 1'b1;
        h0 = mk(HEAD_FLIT, 4'd2, 10'h100);
        b0 = mk(BODY_FLIT, 4'd0, 10'h101);
        t0 = mk(TAIL_FLIT, 4'd0, 10'h102);
        h2 = mk(HEAD_FLIT, 4'd15, 10'h200);
        t2 = mk(TAIL_FLIT, 4'd0, 10'h201);
        exp_push(0, h0, 1'b1);
        exp_push(0, b0, 1'b1);
        exp_push(0, t0, 1'b1);
        exp_push(2, h2, 1'b1);
        exp_push(2, t2, 1'b1);
        set_lane(0, 1'b1, h0);
        step();
        set_lane(0, 1'b1, b0);
        set_lane(2, 1'b1, h2);
        step();
        set_lane(0, 1'b1, t0);
        set_lane(2, 1'b1, t2);
        step();
        in_valid = '0;
        drain(10);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL wormhole_unlock: got locked=%b required 0", locked); end
    endtask

    task automatic test_backpressure();
        int acc [N];
        logic [SW-1:0] sel0;
        logic [FLIT_SIZE-1:0] out0;
        logic seen, stable;
        do_reset();
        out_avail = 1'b0;
        seen   = 1'b0;
        stable = 1'b1;
        sel0   = '0;
        out0   = '0;
        for (int i = 0; i < N; i++) acc[i] = 0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) begin
                set_lane(i, 1'b1, mk(SINGLE_FLIT, 4'd4, 10'(i*64 + c)));
                if (in_avail[i]) acc[i]++;
            end
            step();
            if (out_valid) begin
                if (!seen) begin
                    sel0 = out_sel;
                    out0 = out;
                    seen = 1'b1;
                end else if (out_sel !== sel0 || out !== out0) begin
                    stable = 1'b0;
                end
            end
        end
        in_valid = '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (acc[i] != DEPTH) begin failures++; $display("FAIL bp_accept_lane%0d: got %0d flits required %0d", i, acc[i], DEPTH); end
        end
        checks++; if (in_avail !== '0) begin failures++; $display("FAIL bp_in_avail: got %b required 0", in_avail); end
        checks++; if (!(seen && stable)) begin failures++; $display("FAIL bp_stable: seen=%b stable=%b required 1 1", seen, stable); end
        checks++; if (sel0 !== '0) begin failures++; $display("FAIL bp_first_sel: got %0d required 0", sel0); end
        for (int j = 0; j < DEPTH; j++)
            for (int i = 0; i < N; i++)
                exp_push(i, mk(SINGLE_FLIT, 4'd4, 10'(i*64 + j)), 1'b0);
        out_avail = 1'b1;
        drain(30);
    endtask

    task automatic test_aging();
        logic [FLIT_SIZE-1:0] f4;
        do_reset();
        out_avail = 1'b1;
        f4 = mk(SINGLE_FLIT, 4'd1, 10'h044);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd0), 1'b0);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd1), 1'b0);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd2), 1'b0);
        exp_push(4, f4, 1'b0);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd3), 1'b0);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd4), 1'b0);
        exp_push(5, mk(SINGLE_FLIT, 4'd7, 10'd5), 1'b0);
        set_lane(4, 1'b1, f4);
        for (int c = 0; c < 6; c++) begin
            set_lane(5, 1'b1, mk(SINGLE_FLIT, 4'd7, 10'(c)));
            step();
            in_valid[4] = 1'b0;
        end
        in_valid = '0;
        drain(12);
    endtask

    task automatic test_orphan();
        logic av [3];
        logic [FLIT_SIZE-1:0] sa, sb_f;
        do_reset();
        out_avail = 1'b1;
        set_lane(3, 1'b1, mk(BODY_FLIT, 4'd0, 10'h0b3));
        step();
        in_valid = '0;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_early: got err=%b required 0", err_orphan); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL orphan_valid0: got %b required 0", out_valid); end
        step();
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_pulse: got err=%b required 1", err_orphan); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL orphan_valid1: got %b required 0", out_valid); end
        step();
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_single: got err=%b required 0", err_orphan); end
        out_avail = 1'b0;
        sa   = mk(SINGLE_FLIT, 4'd1, 10'h0c0);
        sb_f = mk(SINGLE_FLIT, 4'd1, 10'h0c1);
        for (int k = 0; k < 3; k++) begin
            set_lane(3, 1'b1, mk(SINGLE_FLIT, 4'd1, 10'(10'h0c0 + k)));
            av[k] = in_avail[3];
            step();
        end
        in_valid = '0;
        checks++; if (av[0] !== 1'b1) begin failures++; $display("FAIL orphan_space0: got in_avail=%b required 1", av[0]); end
        checks++; if (av[1] !== 1'b1) begin failures++; $display("FAIL orphan_space1: got in_avail=%b required 1", av[1]); end
        checks++; if (av[2] !== 1'b0) begin failures++; $display("FAIL orphan_space2: got in_avail=%b required 0", av[2]); end
        exp_push(3, sa, 1'b0);
        exp_push(3, sb_f, 1'b0);
        out_avail = 1'b1;
        drain(8);
    endtask

    task automatic test_reset_midpacket();
        logic [FLIT_SIZE-1:0] h, b, b2, s;
        do_reset();
        out_avail = 1'b1;
        h  = mk(HEAD_FLIT, 4'd6, 10'h310);
        b  = mk(BODY_FLIT, 4'd0, 10'h311);
        b2 = mk(BODY_FLIT, 4'd0, 10'h312);
        s  = mk(SINGLE_FLIT, 4'd2, 10'h3a0);
        exp_push(1, h, 1'b1);
        exp_push(1, b, 1'b1);
        set_lane(1, 1'b1, h);
        step();
        set_lane(1, 1'b1, b);
        step();
        set_lane(1, 1'b1, b2);
        step();
        in_valid = '0;
        checks++; if (out_valid !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL mid_pre: got valid=%b locked=%b required 1 1", out_valid, locked); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_rst_locked: got %b required 0", locked); end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_avail !== '1) begin failures++; $display("FAIL mid_in_avail: got %b required all ones", in_avail); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked_after: got %b required 0", locked); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_sb: %0d outstanding required 0", sb.size()); sb.delete(); end
        exp_push(0, s, 1'b0);
        set_lane(0, 1'b1, s);
        step();
        in_valid = '0;
        step();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_latency: %0d outstanding after one cycle required 0", sb.size()); sb.delete(); end
        drain(4);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_wormhole();
        test_backpressure();
        test_aging();
        test_orphan();
        test_reset_midpacket();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
